// File: rtl/uart_char_decoder_if.sv
// Bus between the UART character decoder and its consumers (character storage, bench).
// rx is the raw serial line into the decoder; the rest are decoder outputs.
interface uart_char_decoder_if;
   logic        rx;
   logic [5:0]  next_character;
   logic        char_ready;
   logic        eof;
   logic        frame_error;
   logic [11:0] char_count;
   logic [2:0]  fsm_state;

   // Handshake: char_ready is a one-cycle valid with no ready path back; the consumer
   // must take next_character in the cycle char_ready is high. The code then holds
   // until the next emission.
   modport master (
      input  rx,
      output next_character, char_ready, eof, frame_error, char_count, fsm_state
   );

   modport slave (
      output rx,
      input  next_character, char_ready, eof, frame_error, char_count, fsm_state
   );
endinterface

// File: rtl/uart_char_decoder.sv
// 8N1 receiver that maps ASCII bytes to 6-bit plotter glyph codes, with a sticky EOT flag.
// fsm_state on the bus exposes the receiver state (0 IDLE .. 4 RECOVER).
module uart_char_decoder #(
   parameter int CLKS_PER_BIT = 434,
   parameter int MAX_CHARS    = 4095
) (
   input  logic                clk,
   input  logic                resetn,
   uart_char_decoder_if.master bus
);
   localparam int CW = $clog2(CLKS_PER_BIT);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      STOP    = 3'd3,
      RECOVER = 3'd4
   } state_t;

   state_t      state;
   logic        rx_meta;
   logic        rs;
   logic [CW-1:0] cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;
   logic [5:0]  next_character;
   logic        char_ready;
   logic        eof;
   logic        frame_error;
   logic [11:0] char_count;

   function automatic logic [5:0] glyph(input logic [7:0] b);
      logic [5:0] code;
      code = 6'd63;
      if (b == 8'h20)                       code = 6'd0;
      else if (b >= 8'h41 && b <= 8'h5A)    code = 6'(b - 8'h40);
      else if (b >= 8'h61 && b <= 8'h7A)    code = 6'(b - 8'h60);
      else if (b >= 8'h30 && b <= 8'h39)    code = 6'(b - 8'h15);
      else if (b == 8'h0A)                  code = 6'd37;
      else if (b == 8'h2E)                  code = 6'd38;
      else if (b == 8'h2C)                  code = 6'd39;
      else if (b == 8'h2D)                  code = 6'd40;
      else if (b == 8'h3F)                  code = 6'd41;
      else if (b == 8'h21)                  code = 6'd42;
      return code;
   endfunction

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state          <= IDLE;
         rx_meta        <= 1'b1;
         rs             <= 1'b1;
         cnt            <= '0;
         bit_idx        <= '0;
         shift          <= '0;
         next_character <= '0;
         char_ready     <= 1'b0;
         eof            <= 1'b0;
         frame_error    <= 1'b0;
         char_count     <= '0;
      end else begin
         rx_meta     <= bus.rx;
         rs          <= rx_meta;
         char_ready  <= 1'b0;
         frame_error <= 1'b0;
         if (cnt != '0) cnt <= cnt - CW'(1);

         case (state)
            IDLE: begin
               if (!rs) begin
                  cnt   <= CW'(CLKS_PER_BIT / 2 - 1);
                  state <= START;
               end
            end
            START: begin
               if (cnt == '0) begin
                  if (rs) begin
                     state <= IDLE;
                  end else begin
                     cnt     <= CW'(CLKS_PER_BIT - 1);
                     bit_idx <= '0;
                     state   <= DATA;
                  end
               end
            end
            DATA: begin
               if (cnt == '0) begin
                  shift   <= {rs, shift[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  cnt     <= CW'(CLKS_PER_BIT - 1);
                  if (bit_idx == 3'd7) state <= STOP;
               end
            end
            STOP: begin
               if (cnt == '0) begin
                  if (rs) begin
                     state <= IDLE;
                     // After EOT every byte is swallowed; CR never reaches storage.
                     if (!eof) begin
                        if (shift == 8'h04) begin
                           eof <= 1'b1;
                        end else if (shift != 8'h0D && char_count != 12'(MAX_CHARS)) begin
                           next_character <= glyph(shift);
                           char_ready     <= 1'b1;
                           char_count     <= char_count + 12'd1;
                        end
                     end
                  end else begin
                     frame_error <= 1'b1;
                     state       <= RECOVER;
                  end
               end
            end
            RECOVER: begin
               if (rs) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.next_character = next_character;
   assign bus.char_ready     = char_ready;
   assign bus.eof            = eof;
   assign bus.frame_error    = frame_error;
   assign bus.char_count     = char_count;
   assign bus.fsm_state      = state;
endmodule

// File: tb/tb_uart_char_decoder.sv
// Directed bench for uart_char_decoder: serial frames in, glyph codes checked from a scoreboard queue.
// A second instance with MAX_CHARS=2 covers the character limit.
module tb_uart_char_decoder;
   localparam int CPB = 8;

   logic clk = 1'b0;
   logic resetn;
   logic resetn_m;
   always #5 clk = ~clk;

   uart_char_decoder_if u_if ();
   uart_char_decoder_if m_if ();

   uart_char_decoder #(.CLKS_PER_BIT(CPB), .MAX_CHARS(4095)) dut (
      .clk(clk), .resetn(resetn), .bus(u_if)
   );
   uart_char_decoder #(.CLKS_PER_BIT(CPB), .MAX_CHARS(2)) dut_m (
      .clk(clk), .resetn(resetn_m), .bus(m_if)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int frame_start = 0;
   int fe_cnt = 0;
   int exp_count = 0;
   logic [5:0] exp_q[$];
   logic [5:0] exp_m_q[$];
   logic prev_cr = 1'b0;
   logic prev_fe = 1'b0;
   logic prev_cr_m = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Scoreboard side: pop one expected code per strobe, check width and position in the frame.
   always @(negedge clk) begin
      if (resetn) begin
         if (u_if.char_ready) begin
            check("strobe_width", 32'(prev_cr), 32'd0);
            check("strobe_in_stop_bit",
                  32'((cyc - frame_start) >= 76 && (cyc - frame_start) <= 82), 32'd1);
            check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("next_character", 32'(u_if.next_character),
                                         32'(exp_q.pop_front()));
         end
         if (u_if.frame_error) begin
            check("frame_error_width", 32'(prev_fe), 32'd0);
            fe_cnt++;
         end
      end
      prev_cr <= u_if.char_ready;
      prev_fe <= u_if.frame_error;
   end

   always @(negedge clk) begin
      if (resetn_m && m_if.char_ready) begin
         check("max_strobe_width", 32'(prev_cr_m), 32'd0);
         check("max_strobe_expected", 32'(exp_m_q.size() != 0), 32'd1);
         if (exp_m_q.size() != 0) check("max_next_character", 32'(m_if.next_character),
                                        32'(exp_m_q.pop_front()));
      end
      prev_cr_m <= m_if.char_ready;
   end

   task automatic drive_line(input bit m, input logic v);
      if (m) m_if.rx = v;
      else   u_if.rx = v;
   endtask

   task automatic send_frame(input bit m, input logic [7:0] b, input logic stop_bit);
      @(negedge clk);
      if (!m) frame_start = cyc;
      drive_line(m, 1'b0);
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         drive_line(m, b[i]);
         repeat (CPB) @(negedge clk);
      end
      drive_line(m, stop_bit);
      repeat (CPB) @(negedge clk);
      drive_line(m, 1'b1);
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic send_char(input logic [7:0] b, input bit strobe, input logic [5:0] code);
      if (strobe) begin
         exp_q.push_back(code);
         exp_count++;
      end
      send_frame(1'b0, b, 1'b1);
   endtask

   logic [7:0] tbl_b[10];
   logic [5:0] tbl_c[10];
   logic [7:0] q_byte;
   int fe_before;

   initial begin
      tbl_b = '{8'h30, 8'h39, 8'h61, 8'h5A, 8'h0A, 8'h2E, 8'h2C, 8'h2D, 8'h3F, 8'h21};
      tbl_c = '{6'd27, 6'd36, 6'd1, 6'd26, 6'd37, 6'd38, 6'd39, 6'd40, 6'd41, 6'd42};
      q_byte = 8'h51;

      // Reset state
      u_if.rx = 1'b1;
      m_if.rx = 1'b1;
      resetn = 1'b0;
      resetn_m = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_next_character", 32'(u_if.next_character), 32'd0);
      check("rst_char_ready", 32'(u_if.char_ready), 32'd0);
      check("rst_eof", 32'(u_if.eof), 32'd0);
      check("rst_frame_error", 32'(u_if.frame_error), 32'd0);
      check("rst_char_count", 32'(u_if.char_count), 32'd0);
      check("rst_fsm_state", 32'(u_if.fsm_state), 32'd0);
      resetn = 1'b1;
      resetn_m = 1'b1;
      repeat (4) @(negedge clk);

      // 'H','i',' ','5'
      send_char(8'h48, 1'b1, 6'd8);
      send_char(8'h69, 1'b1, 6'd9);
      send_char(8'h20, 1'b1, 6'd0);
      send_char(8'h35, 1'b1, 6'd32);
      check("hi5_count", 32'(u_if.char_count), 32'(exp_count));
      check("hi5_held_code", 32'(u_if.next_character), 32'd32);

      // False start: 3-cycle glitch
      fe_before = fe_cnt;
      @(negedge clk);
      u_if.rx = 1'b0;
      repeat (3) @(negedge clk);
      u_if.rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check("false_start_state", 32'(u_if.fsm_state), 32'd0);
      check("false_start_no_fe", 32'(fe_cnt), 32'(fe_before));
      check("false_start_count", 32'(u_if.char_count), 32'(exp_count));
      send_char(8'h41, 1'b1, 6'd1);

      // Bad stop bit
      fe_before = fe_cnt;
      send_frame(1'b0, 8'h41, 1'b0);
      check("bad_stop_fe", 32'(fe_cnt), 32'(fe_before + 1));
      check("bad_stop_count", 32'(u_if.char_count), 32'(exp_count));
      check("bad_stop_state", 32'(u_if.fsm_state), 32'd0);
      send_char(8'h42, 1'b1, 6'd2);

      // Unknown glyphs and lowercase
      send_char(8'h23, 1'b1, 6'd63);
      send_char(8'h7E, 1'b1, 6'd63);
      send_char(8'h7A, 1'b1, 6'd26);
      for (int i = 0; i < 10; i++) send_char(tbl_b[i], 1'b1, tbl_c[i]);
      check("map_count", 32'(u_if.char_count), 32'(exp_count));

      // Break: line held low for many frame times
      fe_before = fe_cnt;
      @(negedge clk);
      u_if.rx = 1'b0;
      repeat (30 * CPB) @(negedge clk);
      check("break_single_fe", 32'(fe_cnt), 32'(fe_before + 1));
      check("break_recover_state", 32'(u_if.fsm_state), 32'd4);
      u_if.rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      check("break_idle_state", 32'(u_if.fsm_state), 32'd0);
      check("break_count", 32'(u_if.char_count), 32'(exp_count));

      // EOT handling
      send_char(8'h41, 1'b1, 6'd1);
      send_char(8'h0D, 1'b0, 6'd0);
      check("cr_dropped_count", 32'(u_if.char_count), 32'(exp_count));
      check("eof_before_eot", 32'(u_if.eof), 32'd0);
      send_char(8'h04, 1'b0, 6'd0);
      check("eof_after_eot", 32'(u_if.eof), 32'd1);
      send_char(8'h43, 1'b0, 6'd0);
      check("after_eof_count", 32'(u_if.char_count), 32'(exp_count));
      check("after_eof_code", 32'(u_if.next_character), 32'd1);
      fe_before = fe_cnt;
      send_frame(1'b0, 8'h44, 1'b0);
      check("after_eof_fe", 32'(fe_cnt), 32'(fe_before + 1));
      check("eof_sticky", 32'(u_if.eof), 32'd1);

      // Reset in the middle of data bit 4 of 'Q'
      @(negedge clk);
      frame_start = cyc;
      u_if.rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         u_if.rx = q_byte[i];
         repeat (CPB) @(negedge clk);
      end
      u_if.rx = q_byte[4];
      repeat (CPB / 2) @(negedge clk);
      check("mid_frame_state", 32'(u_if.fsm_state), 32'd2);
      #1 resetn = 1'b0;
      #1;
      check("async_rst_next_character", 32'(u_if.next_character), 32'd0);
      check("async_rst_char_count", 32'(u_if.char_count), 32'd0);
      check("async_rst_eof", 32'(u_if.eof), 32'd0);
      check("async_rst_char_ready", 32'(u_if.char_ready), 32'd0);
      check("async_rst_frame_error", 32'(u_if.frame_error), 32'd0);
      check("async_rst_state", 32'(u_if.fsm_state), 32'd0);
      u_if.rx = 1'b1;
      exp_count = 0;
      repeat (4) @(negedge clk);
      resetn = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      send_char(q_byte, 1'b1, 6'd17);
      check("post_reset_count", 32'(u_if.char_count), 32'd1);
      check("post_reset_eof", 32'(u_if.eof), 32'd0);

      // Character limit on the MAX_CHARS=2 instance
      exp_m_q.push_back(6'd1);
      send_frame(1'b1, 8'h41, 1'b1);
      exp_m_q.push_back(6'd2);
      send_frame(1'b1, 8'h42, 1'b1);
      send_frame(1'b1, 8'h43, 1'b1);
      check("max_count_holds", 32'(m_if.char_count), 32'd2);
      check("max_code_holds", 32'(m_if.next_character), 32'd2);
      check("max_no_eof", 32'(m_if.eof), 32'd0);

      repeat (4) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check("max_scoreboard_drained", 32'(exp_m_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
